// File: rtl/addr_gen_pkg.sv
// Shared encodings for the address generator: sequencing modes and ping-pong direction.
package addr_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/addr_step_calc.sv
// Next-state for one enabled step: count, direction, wrap pulse and one-shot done.
// Purely combinational; bounds are compared one bit wider so count+STEP never aliases.
module addr_step_calc
  import addr_gen_pkg::*;
#(
  parameter int AW   = 4,
  parameter int STEP = 1
) (
  input  logic [AW-1:0] i_count,
  input  dir_e          i_dir,
  input  logic          i_done,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_lo,
  input  logic [AW-1:0] i_hi,
  output logic [AW-1:0] o_nxt_count,
  output dir_e          o_nxt_dir,
  output logic          o_nxt_done,
  output logic          o_nxt_wrap
);

  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW:0]   STEP_X = (AW+1)'(STEP);

  logic [AW:0]   w_up_x;
  logic [AW:0]   w_lo_step_x;
  logic          w_over_hi;
  logic          w_under_lo;
  logic          w_out_of_range;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_dec;

  assign w_up_x         = {1'b0, i_count} + STEP_X;
  assign w_lo_step_x    = {1'b0, i_lo} + STEP_X;
  assign w_over_hi      = w_up_x > {1'b0, i_hi};
  assign w_under_lo     = {1'b0, i_count} < w_lo_step_x;
  assign w_out_of_range = (i_count < i_lo) || (i_count > i_hi);
  assign w_inc          = i_count + STEP_A;
  assign w_dec          = i_count - STEP_A;

  always_comb begin
    o_nxt_count = i_count;
    o_nxt_dir   = i_dir;
    o_nxt_done  = i_done;
    o_nxt_wrap  = 1'b0;

    if ((i_mode == MODE_ONE) && i_done) begin
      // finished one-shot ignores enable until load, reset or mode change
      o_nxt_count = i_count;
    end else if (w_out_of_range) begin
      o_nxt_count = (i_mode == MODE_DOWN) ? i_hi : i_lo;
      o_nxt_dir   = DIR_UP;
      o_nxt_wrap  = 1'b1;
    end else begin
      case (i_mode)
        MODE_UP: begin
          if (w_over_hi) begin
            o_nxt_count = i_lo;
            o_nxt_wrap  = 1'b1;
          end else begin
            o_nxt_count = w_inc;
          end
        end
        MODE_DOWN: begin
          if (w_under_lo) begin
            o_nxt_count = i_hi;
            o_nxt_wrap  = 1'b1;
          end else begin
            o_nxt_count = w_dec;
          end
        end
        MODE_PP: begin
          if (i_dir == DIR_UP) begin
            if (w_over_hi) begin
              // reverse without repeating the endpoint, never below lo
              o_nxt_dir   = DIR_DOWN;
              o_nxt_count = w_under_lo ? i_lo : w_dec;
              o_nxt_wrap  = 1'b1;
            end else begin
              o_nxt_count = w_inc;
            end
          end else begin
            if (w_under_lo) begin
              o_nxt_dir   = DIR_UP;
              o_nxt_count = w_over_hi ? i_hi : w_inc;
              o_nxt_wrap  = 1'b1;
            end else begin
              o_nxt_count = w_dec;
            end
          end
        end
        default: begin
          if (w_over_hi) begin
            o_nxt_count = i_hi;
            o_nxt_done  = 1'b1;
            o_nxt_wrap  = 1'b1;
          end else begin
            o_nxt_count = w_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/addr_gen_multi.sv
// Multi-mode address generator: state on rising edge, addr_out re-registered on falling edge.
// Count changes reach addr_out half a cycle later; reset clears everything asynchronously.
module addr_gen_multi
  import addr_gen_pkg::*;
#(
  parameter int AW   = 4,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] addr_out,
  output logic          wrap,
  output logic          done
);

  logic [AW-1:0] r_count;
  dir_e          r_dir;
  logic          r_wrap;
  logic          r_done;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_addr_out;

  logic          w_mode_chg;
  dir_e          w_dir_eff;
  logic          w_done_eff;
  logic [AW-1:0] w_nxt_count;
  dir_e          w_nxt_dir;
  logic          w_nxt_done;
  logic          w_nxt_wrap;

  // a mode change clears done and forces dir up outside ping-pong, even on a held cycle
  assign w_mode_chg = (mode != r_mode);
  assign w_dir_eff  = (mode == MODE_PP) ? r_dir : DIR_UP;
  assign w_done_eff = w_mode_chg ? 1'b0 : r_done;

  addr_step_calc #(
    .AW   (AW),
    .STEP (STEP)
  ) u_step_calc (
    .i_count     (r_count),
    .i_dir       (w_dir_eff),
    .i_done      (w_done_eff),
    .i_mode      (mode),
    .i_lo        (lo),
    .i_hi        (hi),
    .o_nxt_count (w_nxt_count),
    .o_nxt_dir   (w_nxt_dir),
    .o_nxt_done  (w_nxt_done),
    .o_nxt_wrap  (w_nxt_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= MODE_UP;
    end else begin
      r_mode <= mode;
      if (load) begin
        r_count <= load_val;
        r_dir   <= DIR_UP;
        r_done  <= 1'b0;
        r_wrap  <= 1'b0;
      end else if (en) begin
        r_count <= w_nxt_count;
        r_dir   <= w_nxt_dir;
        r_done  <= w_nxt_done;
        r_wrap  <= w_nxt_wrap;
      end else begin
        r_dir   <= w_dir_eff;
        r_done  <= w_done_eff;
        r_wrap  <= 1'b0;
      end
    end
  end

  // falling-edge copy gives downstream rising-edge samplers a settled address
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_out <= '0;
    end else begin
      r_addr_out <= r_count;
    end
  end

  assign addr_out = r_addr_out;
  assign wrap     = r_wrap;
  assign done     = r_done;

endmodule

// File: tb/tb_addr_gen_multi.sv
// Directed bench: STEP=1 and STEP=4 instances share stimulus; expected values are hand tables.
module tb_addr_gen_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] a1;
  logic       w1;
  logic       d1;
  logic [3:0] a4;
  logic       w4;
  logic       d4;

  int n_vec  = 0;
  int n_miss = 0;

  int t2_addr [7];
  int t2_wrap [7];
  int t3_addr [5];
  int t3_wrap [5];
  int t3_done [5];

  addr_gen_multi #(.AW(4), .STEP(1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .addr_out (a1),
    .wrap     (w1),
    .done     (d1)
  );

  addr_gen_multi #(.AW(4), .STEP(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .addr_out (a4),
    .wrap     (w4),
    .done     (d4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // called just after a falling edge; reset low spans no rising edge
  task automatic rst_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    t2_addr = '{3, 4, 5, 4, 3, 2, 3};
    t2_wrap = '{0, 0, 0, 1, 0, 0, 1};
    t3_addr = '{4, 8, 9, 9, 9};
    t3_wrap = '{0, 0, 1, 0, 0};
    t3_done = '{0, 0, 1, 1, 1};

    reset = 1'b0; en = 1'b0; load = 1'b0; mode = 2'b00;
    lo = 4'd0; hi = 4'd15; load_val = 4'd0;

    #2;
    chk("rst_addr", 32'(a1), 0);
    chk("rst_wrap", 32'(w1), 0);
    chk("rst_done", 32'(d1), 0);

    // 1: up-wrap full range, addr only moves on falling edges
    #5 reset = 1'b1;
    at_neg();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      at_pos();
      chk("t1_hold", 32'(a1), 32'(i % 16));
      chk("t1_wrap", 32'(w1), (i % 16 == 15) ? 1 : 0);
      at_neg();
      chk("t1_addr", 32'(a1), 32'((i + 1) % 16));
    end

    // 2: ping-pong 2..5 starting from a load
    en = 1'b0; mode = 2'b10; lo = 4'd2; hi = 4'd5; load = 1'b1; load_val = 4'd2;
    at_pos();
    chk("t2_load_wrap", 32'(w1), 0);
    at_neg();
    chk("t2_load_addr", 32'(a1), 2);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      at_pos();
      chk("t2_wrap", 32'(w1), 32'(t2_wrap[i]));
      at_neg();
      chk("t2_addr", 32'(a1), 32'(t2_addr[i]));
    end

    // 3: one-shot 0..9 with STEP=4
    en = 1'b0; mode = 2'b11; lo = 4'd0; hi = 4'd9;
    rst_pulse();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_pos();
      chk("t3_wrap", 32'(w4), 32'(t3_wrap[i]));
      chk("t3_done", 32'(d4), 32'(t3_done[i]));
      at_neg();
      chk("t3_addr", 32'(a4), 32'(t3_addr[i]));
    end
    load = 1'b1; load_val = 4'd0;
    at_pos();
    chk("t3_load_done", 32'(d4), 0);
    chk("t3_load_wrap", 32'(w4), 0);
    at_neg();
    chk("t3_load_addr", 32'(a4), 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_pos();
      chk("t3b_wrap", 32'(w4), 32'(t3_wrap[i]));
      chk("t3b_done", 32'(d4), 32'(t3_done[i]));
      at_neg();
      chk("t3b_addr", 32'(a4), 32'(t3_addr[i]));
    end
    en = 1'b0; mode = 2'b00;
    at_pos();
    chk("t3_modechg_done", 32'(d4), 0);
    chk("t3_modechg_wrap", 32'(w4), 0);
    at_neg();
    chk("t3_modechg_addr", 32'(a4), 9);

    // 4: down-wrap 3..12 from an out-of-range count of 0
    mode = 2'b01; lo = 4'd3; hi = 4'd12;
    rst_pulse();
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      at_pos();
      chk("t4_wrap", 32'(w1), (k == 0 || k == 10) ? 1 : 0);
      at_neg();
      chk("t4_addr", 32'(a1), (k == 0 || k == 10) ? 12 : 32'(12 - k));
    end

    // 5: reset mid-sequence, then load beats enable
    en = 1'b0; mode = 2'b00; lo = 4'd0; hi = 4'd15;
    rst_pulse();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      at_pos();
      at_neg();
    end
    chk("t5_pre_addr", 32'(a1), 7);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_addr", 32'(a1), 0);
    chk("t5_async_wrap", 32'(w1), 0);
    chk("t5_async_done", 32'(d1), 0);
    at_neg();
    chk("t5_held_addr", 32'(a1), 0);
    #1 reset = 1'b1;
    at_pos();
    chk("t5_first_wrap", 32'(w1), 0);
    at_neg();
    chk("t5_first_addr", 32'(a1), 1);
    load = 1'b1; load_val = 4'd5;
    at_pos();
    chk("t5_load_wrap", 32'(w1), 0);
    at_neg();
    chk("t5_load_addr", 32'(a1), 5);
    load = 1'b0;
    at_pos();
    at_neg();
    chk("t5_after_load", 32'(a1), 6);

    // 6: degenerate range lo == hi
    en = 1'b0; mode = 2'b00; lo = 4'd6; hi = 4'd6;
    rst_pulse();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_pos();
      chk("t6_wrap", 32'(w1), 1);
      at_neg();
      chk("t6_addr", 32'(a1), 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
